// File: rtl/screen_scanner_pkg.sv
// screen_scanner shared definitions
// screen geometry, raster defaults, counter types
package screen_pkg;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int SCREEN_WORDS  = 8192;
  localparam int SCREEN_BASE   = 16384;

  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 64;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 32;

  localparam int HW = 10;
  localparam int VW = 9;
  localparam int AW = 13;

  typedef logic [HW-1:0] hcnt_t;
  typedef logic [VW-1:0] vcnt_t;
  typedef logic [AW-1:0] sadr_t;

  typedef struct packed {
    hcnt_t h;
    vcnt_t v;
    hcnt_t hn;
    vcnt_t vn;
    logic  act;
    logic  hs;
    logic  vs;
  } tm_t;

  function automatic sadr_t word_adr(
    input vcnt_t      row,
    input logic [4:0] col
  );
    return AW'({row, col});
  endfunction

endpackage

// File: rtl/screen_scanner_if.sv
// screen_scanner memory read port and video outputs
// master = scanner, slave = memory/display side
interface screen_scanner_if;
  import screen_pkg::*;

  logic        scr_rd;
  sadr_t       scr_adr;
  logic [15:0] scr_data;
  logic        pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output scr_rd, scr_adr,
    output pixel, de, hsync, vsync, frame_start,
    input  scr_data
  );

  modport slave (
    input  scr_rd, scr_adr,
    input  pixel, de, hsync, vsync, frame_start,
    output scr_data
  );

endinterface

// File: rtl/screen_scanner_video_timing.sv
// raster counters with sync and active decode
// also exposes next position so fetches can be registered
module video_timing
  import screen_pkg::*;
#(
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_ACT  = SCREEN_H
) (
  input  logic clk_i,
  input  logic rst_ni,
  output tm_t  tm_o
);

  localparam int H_TOTAL = SCREEN_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam hcnt_t H_LAST = hcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 1);
  localparam hcnt_t H_ACT  = hcnt_t'(SCREEN_W);
  localparam vcnt_t V_ACTV = vcnt_t'(V_ACT);
  localparam hcnt_t HS_BEG = hcnt_t'(SCREEN_W + H_FP);
  localparam hcnt_t HS_END = hcnt_t'(SCREEN_W + H_FP + H_SYNC);
  localparam vcnt_t VS_BEG = vcnt_t'(V_ACT + V_FP);
  localparam vcnt_t VS_END = vcnt_t'(V_ACT + V_FP + V_SYNC);

  hcnt_t h_q, h_d;
  vcnt_t v_q, v_d;

  // advance h, wrap into v at line end
  always_comb begin
    h_d = h_q + hcnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + vcnt_t'(1);
    end
  end

  // raster position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign tm_o.h   = h_q;
  assign tm_o.v   = v_q;
  assign tm_o.hn  = h_d;
  assign tm_o.vn  = v_d;
  assign tm_o.act = (h_q < H_ACT) && (v_q < V_ACTV);
  assign tm_o.hs  = (h_q >= HS_BEG) && (h_q < HS_END);
  assign tm_o.vs  = (v_q >= VS_BEG) && (v_q < VS_END);

endmodule

// File: rtl/screen_scanner.sv
// raster read-out of the screen map
// word fetch, hold, LSB-first serializer, registered video
module screen_scanner
  import screen_pkg::*;
#(
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_ACT = 1'b1,
  parameter int   V_ACT    = SCREEN_H
) (
  input logic              clk,
  input logic              reset,
  screen_scanner_if.master bus
);

  localparam int H_TOTAL = SCREEN_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam hcnt_t H_PRE   = hcnt_t'(H_TOTAL - 2);
  localparam hcnt_t H_FLAST = hcnt_t'(SCREEN_W - 2);
  localparam vcnt_t V_LAST  = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t V_ACTV  = vcnt_t'(V_ACT);

  tm_t tm;

  video_timing #(
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .V_ACT  (V_ACT)
  ) u_timing (
    .clk_i  (clk),
    .rst_ni (reset),
    .tm_o   (tm)
  );

  hcnt_t       hn2;
  logic [4:0]  col;
  vcnt_t       nrow;
  logic        rd_d, rd_q;
  sadr_t       adr_d, adr_q;
  logic        pend_q;
  logic [15:0] hold_q;
  logic [15:0] src, shift_d, shift_q;
  logic        pix_d, pix_q;
  logic        de_q, hs_q, vs_q, fs_q;

  // request word col k two clocks ahead of pixel 16k
  always_comb begin
    hn2   = tm.hn + hcnt_t'(2);
    col   = 5'(hn2 >> 4);
    nrow  = (tm.vn == V_LAST) ? '0 : tm.vn + vcnt_t'(1);
    rd_d  = 1'b0;
    adr_d = adr_q;
    if (tm.hn < H_FLAST && tm.hn[3:0] == 4'he &&
        tm.vn < V_ACTV) begin
      rd_d  = 1'b1;
      adr_d = word_adr(tm.vn, col);
    end else if (tm.hn == H_PRE && nrow < V_ACTV) begin
      rd_d  = 1'b1;
      adr_d = word_adr(nrow, 5'd0);
    end
  end

  // fresh word enters at each 16-pixel boundary
  always_comb begin
    src     = (tm.h[3:0] == 4'h0) ? hold_q : shift_q;
    shift_d = {1'b0, src[15:1]};
    pix_d   = tm.act & src[0];
  end

  // fetch strobe, read capture and serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      adr_q   <= '0;
      pend_q  <= 1'b0;
      hold_q  <= '0;
      shift_q <= '0;
    end else begin
      rd_q    <= rd_d;
      adr_q   <= adr_d;
      pend_q  <= rd_q;
      shift_q <= shift_d;
      if (pend_q) hold_q <= bus.scr_data;
    end
  end

  // video outputs lag the counters by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_ACT;
      vs_q  <= ~SYNC_ACT;
      fs_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      de_q  <= tm.act;
      hs_q  <= tm.hs ? SYNC_ACT : ~SYNC_ACT;
      vs_q  <= tm.vs ? SYNC_ACT : ~SYNC_ACT;
      fs_q  <= tm.act && tm.h == '0 && tm.v == '0;
    end
  end

  assign bus.scr_rd      = rd_q;
  assign bus.scr_adr     = adr_q;
  assign bus.pixel       = pix_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.frame_start = fs_q;

endmodule
